// File: rtl/cbc_feistel_pkg.sv
// Shared types and default sizing for the CBC Feistel round sequencer.
// Default geometry: 5 rounds, 128-bit round keys, 256-bit blocks.
package cbc_feistel_pkg;

  localparam int DEF_ROUND      = 5;
  localparam int DEF_KEY_SIZE   = 128;
  localparam int DEF_BLOCK_SIZE = 256;

  localparam int H     = DEF_BLOCK_SIZE / 2;
  localparam int CNT_W = $clog2(DEF_ROUND);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    KEY_WAIT = 3'd1,
    READY    = 3'd2,
    RUN      = 3'd3,
    WAIT_F   = 3'd4,
    OUT      = 3'd5
  } seq_state_t;

  typedef logic [H-1:0] half_t;

endpackage

// File: rtl/cbc_round_sequencer.sv
// Iterative CBC Feistel sequencer: key-load gating, CBC chaining, round-function drive, ciphertext output.
// Optional macro CBC_SEQ_ECB_BYPASS_EN adds ecb_mode (skip chaining per block).
module cbc_round_sequencer
  import cbc_feistel_pkg::*;
#(
  parameter int ROUND      = DEF_ROUND,
  parameter int KEY_SIZE   = DEF_KEY_SIZE,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       key_tvalid,
  output logic                       key_tready,
  output logic                       ks_tvalid,
  input  logic                       ks_valid,
  input  logic                       in_tvalid,
  output logic                       in_tready,
  input  logic                       in_first,
  input  logic [BLOCK_SIZE-1:0]      plaintext,
  input  logic [BLOCK_SIZE-1:0]      iv,
`ifdef CBC_SEQ_ECB_BYPASS_EN
  input  logic                       ecb_mode,
`endif
  output logic [$clog2(ROUND)-1:0]   key_sel,
  output logic                       f_start,
  output logic [BLOCK_SIZE/2-1:0]    f_in,
  input  logic                       f_done,
  input  logic [BLOCK_SIZE/2-1:0]    f_out,
  output logic                       out_tvalid,
  input  logic                       out_tready,
  output logic [BLOCK_SIZE-1:0]      ciphertext
);

  localparam int HALF  = BLOCK_SIZE / 2;
  localparam int SEL_W = $clog2(ROUND);

  if (ROUND < 2) begin : g_bad_round
    $error("cbc_round_sequencer: ROUND must be at least 2");
  end
  if ((BLOCK_SIZE % 2) != 0) begin : g_bad_block
    $error("cbc_round_sequencer: BLOCK_SIZE must be even");
  end
  if (KEY_SIZE < 1) begin : g_bad_key
    $error("cbc_round_sequencer: KEY_SIZE must be positive");
  end

  seq_state_t              state_r, state_nxt_s;
  logic [HALF-1:0]         l_r, l_nxt_s, r_r, r_nxt_s;
  logic [SEL_W-1:0]        cnt_r, cnt_nxt_s;
  logic [BLOCK_SIZE-1:0]   chain_r, chain_nxt_s;
  logic                    key_loaded_r, key_loaded_nxt_s;

  logic                    key_tready_r, key_tready_nxt_s;
  logic                    in_tready_r, in_tready_nxt_s;
  logic                    ks_tvalid_r, ks_tvalid_nxt_s;
  logic [SEL_W-1:0]        key_sel_r, key_sel_nxt_s;
  logic                    f_start_r, f_start_nxt_s;
  logic [HALF-1:0]         f_in_r, f_in_nxt_s;
  logic                    out_tvalid_r, out_tvalid_nxt_s;
  logic [BLOCK_SIZE-1:0]   ciphertext_r, ciphertext_nxt_s;

  logic [BLOCK_SIZE-1:0]   chain_sel_s, x_s;
  logic [HALF-1:0]         new_r_s;
  logic                    last_s, key_req_s, accept_s, chain_keep_s;

  assign chain_sel_s = in_first ? iv : chain_r;
  assign new_r_s     = l_r ^ f_out;
  assign last_s      = (cnt_r == SEL_W'(ROUND - 1));
  assign key_req_s   = key_tvalid && key_tready_r;
  assign accept_s    = (state_r == READY) && !key_req_s && in_tvalid && in_tready_r && key_loaded_r;

`ifdef CBC_SEQ_ECB_BYPASS_EN
  logic ecb_r;

  assign x_s          = ecb_mode ? plaintext : (plaintext ^ chain_sel_s);
  assign chain_keep_s = ecb_r;

  // Remember the block's ECB choice so OUT knows whether to advance the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      ecb_r <= 1'b0;
    end else if (accept_s) begin
      ecb_r <= ecb_mode;
    end else begin
      ecb_r <= ecb_r;
    end
  end
`else
  assign x_s          = plaintext ^ chain_sel_s;
  assign chain_keep_s = 1'b0;
`endif

  // Next-state, datapath and next-output logic; outputs are registered from these values.
  always_comb begin
    state_nxt_s      = state_r;
    l_nxt_s          = l_r;
    r_nxt_s          = r_r;
    cnt_nxt_s        = cnt_r;
    chain_nxt_s      = chain_r;
    key_loaded_nxt_s = key_loaded_r;
    key_tready_nxt_s = 1'b0;
    in_tready_nxt_s  = 1'b0;
    ks_tvalid_nxt_s  = 1'b0;
    f_start_nxt_s    = 1'b0;
    key_sel_nxt_s    = key_sel_r;
    f_in_nxt_s       = f_in_r;
    out_tvalid_nxt_s = out_tvalid_r;
    ciphertext_nxt_s = ciphertext_r;

    case (state_r)
      IDLE: begin
        if (key_req_s) begin
          ks_tvalid_nxt_s  = 1'b1;
          key_loaded_nxt_s = 1'b0;
          chain_nxt_s      = '0;
          state_nxt_s      = KEY_WAIT;
        end else begin
          key_tready_nxt_s = 1'b1;
        end
      end
      KEY_WAIT: begin
        if (ks_valid) begin
          key_loaded_nxt_s = 1'b1;
          key_tready_nxt_s = 1'b1;
          in_tready_nxt_s  = 1'b1;
          state_nxt_s      = READY;
        end else begin
          state_nxt_s = KEY_WAIT;
        end
      end
      READY: begin
        // A key reload outranks a plaintext offered in the same cycle.
        if (key_req_s) begin
          ks_tvalid_nxt_s  = 1'b1;
          key_loaded_nxt_s = 1'b0;
          chain_nxt_s      = '0;
          state_nxt_s      = KEY_WAIT;
        end else if (accept_s) begin
          l_nxt_s       = x_s[BLOCK_SIZE-1:HALF];
          r_nxt_s       = x_s[HALF-1:0];
          cnt_nxt_s     = '0;
          key_sel_nxt_s = '0;
          f_in_nxt_s    = x_s[HALF-1:0];
          f_start_nxt_s = 1'b1;
          state_nxt_s   = RUN;
        end else begin
          key_tready_nxt_s = 1'b1;
          in_tready_nxt_s  = 1'b1;
        end
      end
      RUN: begin
        state_nxt_s = WAIT_F;
      end
      WAIT_F: begin
        if (f_done) begin
          l_nxt_s = r_r;
          r_nxt_s = new_r_s;
          if (last_s) begin
            cnt_nxt_s        = '0;
            ciphertext_nxt_s = {r_r, new_r_s};
            out_tvalid_nxt_s = 1'b1;
            state_nxt_s      = OUT;
          end else begin
            cnt_nxt_s     = cnt_r + SEL_W'(1);
            key_sel_nxt_s = cnt_r + SEL_W'(1);
            f_in_nxt_s    = new_r_s;
            f_start_nxt_s = 1'b1;
            state_nxt_s   = RUN;
          end
        end else begin
          state_nxt_s = WAIT_F;
        end
      end
      OUT: begin
        if (out_tready) begin
          if (chain_keep_s) begin
            chain_nxt_s = chain_r;
          end else begin
            chain_nxt_s = ciphertext_r;
          end
          out_tvalid_nxt_s = 1'b0;
          key_tready_nxt_s = 1'b1;
          in_tready_nxt_s  = 1'b1;
          state_nxt_s      = READY;
        end else begin
          state_nxt_s = OUT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset drops any block in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      l_r          <= '0;
      r_r          <= '0;
      cnt_r        <= '0;
      chain_r      <= '0;
      key_loaded_r <= 1'b0;
      key_tready_r <= 1'b0;
      in_tready_r  <= 1'b0;
      ks_tvalid_r  <= 1'b0;
      key_sel_r    <= '0;
      f_start_r    <= 1'b0;
      f_in_r       <= '0;
      out_tvalid_r <= 1'b0;
      ciphertext_r <= '0;
    end else begin
      state_r      <= state_nxt_s;
      l_r          <= l_nxt_s;
      r_r          <= r_nxt_s;
      cnt_r        <= cnt_nxt_s;
      chain_r      <= chain_nxt_s;
      key_loaded_r <= key_loaded_nxt_s;
      key_tready_r <= key_tready_nxt_s;
      in_tready_r  <= in_tready_nxt_s;
      ks_tvalid_r  <= ks_tvalid_nxt_s;
      key_sel_r    <= key_sel_nxt_s;
      f_start_r    <= f_start_nxt_s;
      f_in_r       <= f_in_nxt_s;
      out_tvalid_r <= out_tvalid_nxt_s;
      ciphertext_r <= ciphertext_nxt_s;
    end
  end

  assign key_tready = key_tready_r;
  assign in_tready  = in_tready_r;
  assign ks_tvalid  = ks_tvalid_r;
  assign key_sel    = key_sel_r;
  assign f_start    = f_start_r;
  assign f_in       = f_in_r;
  assign out_tvalid = out_tvalid_r;
  assign ciphertext = ciphertext_r;

endmodule
